// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the class demo processor.
// Steps every instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath controls from the current state and the latched opcode. Adds a
// memory wait handshake, BEQZ, HALT, an illegal-opcode trap and a saturating
// retired-instruction counter.
module multicycle_control #(
  parameter int OPW  = 6,
  parameter int ALUW = 5,
  parameter int CNTW = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [OPW-1:0]  Instr,
  input  logic            InstrValid,
  input  logic            MemReady,
  input  logic            Zero,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            Branch,
  output logic            RegDst,
  output logic            ALUSrc,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic [ALUW-1:0] ALUOp,
  output logic            Busy,
  output logic            Halted,
  output logic            IllegalOp,
  output logic [CNTW-1:0] RetireCnt
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  localparam logic [OPW-1:0] OP_STORE = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(2);
  localparam logic [OPW-1:0] OP_LOAD  = OPW'(3);
  localparam logic [OPW-1:0] OP_BEQZ  = OPW'(4);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(5);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(6);

  localparam logic [ALUW-1:0] ALU_ADD  = '0;
  localparam logic [ALUW-1:0] ALU_SUB  = ALUW'(5'b00001);
  localparam logic [ALUW-1:0] ALU_PASS = ALUW'(5'b11000);

  state_t          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            retire;

  // Opcode classes shared by EXEC, MEM and WB so the datapath sees stable
  // controls from EXEC through writeback.
  logic is_rtype, is_imm, is_mem, is_arith;
  assign is_rtype = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_imm   = (op_q == OP_ADDI) || (op_q == OP_LOAD) || (op_q == OP_STORE);
  assign is_mem   = (op_q == OP_LOAD) || (op_q == OP_STORE);
  assign is_arith = is_rtype || is_imm;

  // State, latched opcode and retire counter; reset aborts any access at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Moore controls; IRWrite/PCWrite also qualify on the
  // handshake inputs of the cycle in which they fire.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    retire    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    Branch    = 1'b0;
    RegDst    = 1'b0;
    ALUSrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUOp     = ALU_PASS;
    Busy      = 1'b1;
    Halted    = 1'b0;
    IllegalOp = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        Busy = 1'b0;
        // Gated by Reset so every output is low while reset is held.
        if (InstrValid && !Reset) begin
          IRWrite = 1'b1;
          op_d    = Instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_q == OP_HALT)     state_d = S_HALT;
        else if (op_q > OP_HALT) state_d = S_TRAP;
        else                     state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_arith) ALUOp = (op_q == OP_SUB) ? ALU_SUB : ALU_ADD;
        ALUSrc = is_imm;
        RegDst = is_rtype;
        if (op_q == OP_BEQZ) begin
          Branch  = 1'b1;
          PCWrite = Zero;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ALUOp    = ALU_ADD;
        ALUSrc   = 1'b1;
        MemRead  = (op_q == OP_LOAD);
        MemWrite = (op_q == OP_STORE);
        if (MemReady) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            PCWrite = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        if (is_arith) ALUOp = (op_q == OP_SUB) ? ALU_SUB : ALU_ADD;
        ALUSrc   = is_imm;
        RegDst   = is_rtype;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        MemtoReg = (op_q == OP_LOAD);
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        Busy   = 1'b0;
        Halted = 1'b1;
      end
      S_TRAP: begin
        Busy      = 1'b0;
        IllegalOp = 1'b1;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // Saturating retire count: holds at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (retire && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  assign RetireCnt = cnt_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle control unit for the class demo processor; successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath controls per state instead of per opcode only.
- Adds a memory wait handshake, a conditional branch, HALT, an illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction fetch port and the datapath: register file, ALU and data memory.

Parameters:
OPW, 6, opcode width; opcodes above 6 are illegal.
ALUW, 5, ALUOp width; must be at least 5.
CNTW, 16, width of the retired-instruction counter.

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
Instr  input  OPW  opcode from fetch; sampled only in FETCH when InstrValid=1
InstrValid  input  1  fetch has a valid opcode
MemReady  input  1  data memory has completed the access this cycle
Zero  input  1  ALU zero flag, used by BEQZ
IRWrite  output  1  latch instruction register
PCWrite  output  1  update PC
Branch  output  1  PC source = branch target
RegDst  output  1  destination = rd field (R-type)
ALUSrc  output  1  ALU B operand = immediate
MemRead  output  1  data memory read request
MemWrite  output  1  data memory write request
MemtoReg  output  1  writeback data comes from memory
RegWrite  output  1  register file write enable
ALUOp  output  ALUW  ALU function
Busy  output  1  high in every state except FETCH, HALT and TRAP
Halted  output  1  high in HALT
IllegalOp  output  1  high in TRAP
RetireCnt  output  CNTW  count of retired instructions

Behaviour:
- Reset (asynchronous, active-high):
  - state = FETCH; opcode register = 0; RetireCnt = 0.
  - All 1-bit outputs = 0; ALUOp = PASS (5'b11000, y=a+0, zero-extended to ALUW).
  - Reset asserted mid-MEM aborts the access immediately; MemWrite/MemRead drop without waiting for a clock edge.
- Opcodes: 0 STORE, 1 ADD, 2 ADDI, 3 LOAD, 4 BEQZ, 5 SUB, 6 HALT; all others illegal.
- ALUOp encodings: ADD = 00000, SUB = 00001, PASS = 11000. ALUOp = PASS in every state except EXEC/MEM/WB of ADD/ADDI/SUB/LOAD/STORE.
- Outputs are Moore: decoded from the current state and the latched opcode only, never from the Instr port.
- FETCH:
  - Waits while InstrValid=0.
  - On InstrValid=1: IRWrite=1 for that cycle, opcode is latched, next state DECODE.
- DECODE: all controls at default. Next state:
  - HALT opcode -> HALT.
  - Illegal opcode -> TRAP.
  - Otherwise -> EXEC.
- EXEC:
  - ALUOp per opcode: ADD/ADDI/LOAD/STORE use ADD; SUB uses SUB.
  - ALUSrc=1 for ADDI, LOAD and STORE.
  - RegDst=1 for ADD and SUB.
  - BEQZ: Branch=1 and PCWrite=Zero; this retires the instruction; next state FETCH.
  - LOAD/STORE -> MEM; all other opcodes -> WB.
- MEM:
  - MemRead=1 (LOAD) or MemWrite=1 (STORE), held every cycle until MemReady=1.
  - Address controls (ALUSrc=1, ALUOp=ADD) are held stable for the whole wait.
  - On MemReady=1: LOAD -> WB; STORE retires (PCWrite=1) -> FETCH.
  - MemReady is ignored in every other state.
- WB:
  - RegWrite=1 and PCWrite=1.
  - MemtoReg=1 for LOAD only.
  - RegDst and ALUSrc keep their EXEC values.
  - Next state FETCH.
- Minimum latency, InstrValid high from FETCH through retirement:
  - BEQZ: 3 cycles.
  - ADD/ADDI/SUB and STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each extra cycle of MemReady=0 adds 1 cycle.
- Non-branch PC increment happens on the PCWrite pulse in the retiring cycle. BEQZ with Zero=0 still retires without a PCWrite; fall-through is handled by the datapath.
- RetireCnt:
  - Increments by 1 in every retiring cycle: BEQZ EXEC, STORE MEM with MemReady=1, WB.
  - Saturates at 2^CNTW-1 and never wraps.
  - HALT and illegal opcodes do not count.
- HALT and TRAP are absorbing states: all controls at default, exit only by Reset. Halted or IllegalOp stays high.
- Never asserted together: MemRead and MemWrite; RegWrite and MemWrite.

Test Plan:
- Reset asserted mid-cycle -> all outputs 0 and ALUOp=11000 immediately without a clock edge; after release with InstrValid=1 and Instr=1 (ADD), IRWrite=1 on the first edge.
- ADD with InstrValid held high -> RegWrite=1, RegDst=1, ALUOp=00000, PCWrite=1 on cycle 4; RetireCnt 0->1; back in FETCH on cycle 5.
- LOAD with MemReady low for 3 MEM cycles -> MemRead=1, ALUSrc=1 for 4 cycles; then WB with MemtoReg=1, RegWrite=1; total latency 8 cycles.
- BEQZ run twice, Zero=1 then Zero=0 -> Branch=1 in EXEC both times; PCWrite=1 first time only; RetireCnt increments by 2.
- Opcode 7, then opcode 6 after a reset -> IllegalOp=1 held over 10 cycles with Instr toggling; then Halted=1, RetireCnt unchanged, no control asserted.
- CNTW=4, 17 back-to-back ADDs -> RetireCnt reaches 15 and stays 15.
